// File: rtl/extmem_pkg.sv
// Shared definitions for the external SRAM controller: FSM states,
// register offsets and register field positions.
package extmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_VID_ACC
    } state_e;

    localparam logic [2:0] OFF_STATUS = 3'd7;

    localparam int BIT_EN    = 7;
    localparam int BIT_WLOCK = 6;
    localparam int BIT_VIOL  = 0;
    localparam int BIT_VPEND = 1;
    localparam int BIT_BUSY  = 2;

    // Bits of a window register that actually hold state; the rest read 0.
    function automatic logic [7:0] win_mask(input int page_bits);
        return 8'hC0 | 8'((1 << page_bits) - 1);
    endfunction

endpackage

// File: rtl/extmem_winreg.sv
// Window register file with write-lock lookup and combinational
// translation of a CPU address into the external SRAM address space.
module extmem_winreg
    import extmem_pkg::*;
#(
    parameter int NWIN      = 4,
    parameter int WIN_SLOT0 = 4,
    parameter int PAGE_BITS = 5,
    parameter int EXT_AW    = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        off,
    input  logic [7:0]        wr_data,
    input  logic [15:0]       ad,
    output logic [7:0]        rd_data,
    output logic [EXT_AW-1:0] xlat_ad,
    output logic              hit_lock
);

    localparam logic [7:0] WIN_MASK = win_mask(PAGE_BITS);

    logic [NWIN*8-1:0] win_flat;
    logic [NWIN-1:0]   hit;

    generate
        for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
            logic [7:0] win_q;
            logic [7:0] win_d;

            always_comb begin
                win_d = win_q;
                if (wr_en && off == 3'(gi)) begin
                    win_d = wr_data & WIN_MASK;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    win_q <= '0;
                end else begin
                    win_q <= win_d;
                end
            end

            assign win_flat[gi*8 +: 8] = win_q;
            assign hit[gi] = win_q[BIT_EN] && (ad[15:13] == 3'(WIN_SLOT0 + gi));
        end
    endgenerate

    // Windows occupy distinct slots, so at most one hit bit is set.
    always_comb begin
        xlat_ad  = EXT_AW'(ad);
        hit_lock = 1'b0;
        rd_data  = 8'h00;
        for (int i = 0; i < NWIN; i++) begin
            if (hit[i]) begin
                xlat_ad  = EXT_AW'({win_flat[i*8 +: PAGE_BITS], ad[12:0]});
                hit_lock = win_flat[i*8 + BIT_WLOCK];
            end
            if (off == 3'(i)) begin
                rd_data = win_flat[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/extmem_ctl.sv
// External SRAM controller: CPU/VPU arbitration, wait-state sequencing
// with CPU clock hold, SRAM strobes and the register block front end.
module extmem_ctl
    import extmem_pkg::*;
#(
    parameter int NWIN      = 4,
    parameter int WIN_SLOT0 = 4,
    parameter int PAGE_BITS = 5,
    parameter int EXT_AW    = 18,
    parameter int WAIT_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       AD,
    input  logic [7:0]        DI,
    output logic [7:0]        DO,
    input  logic              rw,
    input  logic              vma,
    input  logic              cs,
    input  logic              ext_sel,
    output logic [7:0]        cpu_rdata,
    output logic              hold,
    input  logic              vreq,
    input  logic [15:0]       vaddr,
    output logic              vack,
    output logic [7:0]        vdata,
    output logic [EXT_AW-1:0] ext_ad,
    input  logic [7:0]        ext_dq_i,
    output logic [7:0]        ext_dq_o,
    output logic              ext_dq_oe,
    output logic              ext_cs,
    output logic              ext_oe_n,
    output logic              ext_we_n
);

    localparam logic [2:0] WC = 3'(WAIT_CYC);

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [EXT_AW-1:0]  ad_q, ad_d;
    logic               vack_q, vack_d;
    logic [7:0]         vdata_q, vdata_d;
    logic               viol_q, viol_d;

    logic               cpu_req, reg_wr, reg_rd, lock_viol, vreq_eff, last_cyc;
    logic [7:0]         win_rd, status;
    logic [EXT_AW-1:0]  xlat_ad;
    logic               hit_lock;

    assign cpu_req   = ext_sel & vma & ~cs;
    assign reg_wr    = cs & vma & ~rw;
    assign reg_rd    = cs & vma & rw;
    assign lock_viol = cpu_req & ~rw & hit_lock;
    // vreq is still high in the vack cycle; it belongs to the request just served.
    assign vreq_eff  = vreq & ~vack_q;
    assign last_cyc  = (cnt_q == WC);

    extmem_winreg #(
        .NWIN      (NWIN),
        .WIN_SLOT0 (WIN_SLOT0),
        .PAGE_BITS (PAGE_BITS),
        .EXT_AW    (EXT_AW)
    ) u_winreg (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (reg_wr),
        .off      (AD[2:0]),
        .wr_data  (DI),
        .ad       (AD),
        .rd_data  (win_rd),
        .xlat_ad  (xlat_ad),
        .hit_lock (hit_lock)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        ad_d    = ad_q;
        vack_d  = 1'b0;
        vdata_d = vdata_q;
        viol_d  = viol_q;
        if (reg_rd && AD[2:0] == OFF_STATUS) begin
            viol_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (vreq_eff) begin
                    state_d = ST_VID_ACC;
                    cnt_d   = 3'd0;
                    ad_d    = EXT_AW'(vaddr);
                end else if (cpu_req) begin
                    if (lock_viol) begin
                        viol_d = 1'b1;
                    end else begin
                        state_d = ST_CPU_ACC;
                        cnt_d   = 3'd0;
                        wr_d    = ~rw;
                        ad_d    = xlat_ad;
                    end
                end
            end
            ST_CPU_ACC: begin
                if (last_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_VID_ACC: begin
                if (last_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    vdata_d = ext_dq_i;
                    vack_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            wr_q    <= 1'b0;
            ad_q    <= '0;
            vack_q  <= 1'b0;
            vdata_q <= 8'h00;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ad_q    <= ad_d;
            vack_q  <= vack_d;
            vdata_q <= vdata_d;
            viol_q  <= viol_d;
        end
    end

    always_comb begin
        status            = 8'h00;
        status[BIT_VIOL]  = viol_q;
        status[BIT_VPEND] = vreq;
        status[BIT_BUSY]  = (state_q != ST_IDLE);
        DO = 8'h00;
        if (reg_rd) begin
            DO = (AD[2:0] == OFF_STATUS) ? status : win_rd;
        end
    end

    // The last CPU_ACC cycle drops hold so the CPU edge ending it samples the SRAM.
    assign hold = (state_q == ST_VID_ACC)
                | ((state_q == ST_IDLE) & cpu_req & vreq)
                | ((state_q == ST_CPU_ACC) & ~last_cyc);

    assign cpu_rdata = ext_dq_i;
    assign vack      = vack_q;
    assign vdata     = vdata_q;
    assign ext_ad    = ad_q;
    assign ext_dq_o  = DI;
    assign ext_cs    = (state_q != ST_IDLE);
    assign ext_oe_n  = ~((state_q == ST_VID_ACC) | ((state_q == ST_CPU_ACC) & ~wr_q));
    assign ext_we_n  = ~((state_q == ST_CPU_ACC) & wr_q & last_cyc);
    assign ext_dq_oe = (state_q == ST_CPU_ACC) & wr_q;

endmodule

// File: tb/tb_extmem_ctl.sv
// Bench for extmem_ctl: register table, hand-written timing sequences and
// random transactions checked against a behavioural memory-map model.
module tb_extmem_ctl;

    localparam int NWIN      = 4;
    localparam int WIN_SLOT0 = 4;
    localparam int PAGE_BITS = 5;
    localparam int EXT_AW    = 18;
    localparam int WAIT_CYC  = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       AD = '0;
    logic [7:0]        DI = '0;
    logic              rw = 1'b1, vma = 1'b0, cs = 1'b0, ext_sel = 1'b0;
    logic              vreq = 1'b0;
    logic [15:0]       vaddr = '0;
    logic [7:0]        ext_dq_i = '0;

    logic [7:0]        DO, cpu_rdata, vdata, ext_dq_o;
    logic              hold, vack, ext_dq_oe, ext_cs, ext_oe_n, ext_we_n;
    logic [EXT_AW-1:0] ext_ad;

    logic [7:0]        w0_DO, w0_cpu_rdata, w0_vdata, w0_ext_dq_o;
    logic              w0_hold, w0_vack, w0_ext_dq_oe, w0_ext_cs, w0_ext_oe_n, w0_ext_we_n;
    logic [EXT_AW-1:0] w0_ext_ad;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_win [8];
    logic       m_viol;

    always #5 clk = ~clk;

    extmem_ctl #(.NWIN(NWIN), .WIN_SLOT0(WIN_SLOT0), .PAGE_BITS(PAGE_BITS),
                 .EXT_AW(EXT_AW), .WAIT_CYC(WAIT_CYC)) u_dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .vma(vma),
        .cs(cs), .ext_sel(ext_sel), .cpu_rdata(cpu_rdata), .hold(hold),
        .vreq(vreq), .vaddr(vaddr), .vack(vack), .vdata(vdata),
        .ext_ad(ext_ad), .ext_dq_i(ext_dq_i), .ext_dq_o(ext_dq_o),
        .ext_dq_oe(ext_dq_oe), .ext_cs(ext_cs), .ext_oe_n(ext_oe_n),
        .ext_we_n(ext_we_n)
    );

    extmem_ctl #(.NWIN(NWIN), .WIN_SLOT0(WIN_SLOT0), .PAGE_BITS(PAGE_BITS),
                 .EXT_AW(EXT_AW), .WAIT_CYC(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(w0_DO), .rw(rw), .vma(vma),
        .cs(cs), .ext_sel(ext_sel), .cpu_rdata(w0_cpu_rdata), .hold(w0_hold),
        .vreq(vreq), .vaddr(vaddr), .vack(w0_vack), .vdata(w0_vdata),
        .ext_ad(w0_ext_ad), .ext_dq_i(ext_dq_i), .ext_dq_o(w0_ext_dq_o),
        .ext_dq_oe(w0_ext_dq_oe), .ext_cs(w0_ext_cs), .ext_oe_n(w0_ext_oe_n),
        .ext_we_n(w0_ext_we_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory-map model: which window owns the 8 KB slot, and where it points.
    function automatic int model_win(input logic [15:0] a);
        int w;
        w = int'(a[15:13]) - WIN_SLOT0;
        if (w >= 0 && w < NWIN && m_win[w][7]) return w;
        return -1;
    endfunction

    function automatic logic [EXT_AW-1:0] model_xlat(input logic [15:0] a);
        int w;
        w = model_win(a);
        if (w < 0) return EXT_AW'(a);
        return EXT_AW'((int'(m_win[w]) % (1 << PAGE_BITS)) * 8192 + int'(a) % 8192);
    endfunction

    function automatic bit model_locked(input logic [15:0] a);
        int w;
        w = model_win(a);
        return (w >= 0) && (m_win[w][6] == 1'b1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_win[i] = 8'h00;
        m_viol = 1'b0;
    endtask

    task automatic reg_write(input logic [2:0] off, input logic [7:0] d);
        tick();
        cs = 1'b1; vma = 1'b1; rw = 1'b0; ext_sel = 1'b0; AD = {13'h0, off}; DI = d;
        tick();
        cs = 1'b0; vma = 1'b0; rw = 1'b1;
        if (int'(off) < NWIN) m_win[off] = d & (8'hC0 | 8'((1 << PAGE_BITS) - 1));
        $display("[%0t] reg write off=%0d data=%02h", $time, off, d);
    endtask

    task automatic reg_read(input logic [2:0] off, input logic [7:0] exp, input string name);
        tick();
        cs = 1'b1; vma = 1'b1; rw = 1'b1; ext_sel = 1'b0; AD = {13'h0, off};
        @(negedge clk);
        check(name, DO, exp);
        $display("[%0t] reg read  off=%0d data=%02h exp=%02h", $time, off, DO, exp);
        tick();
        cs = 1'b0; vma = 1'b0;
        if (off == 3'd7) m_viol = 1'b0;
    endtask

    task automatic cpu_ext(input logic [15:0] a, input logic rd, input logic [7:0] wdata,
                           input logic [7:0] sram);
        logic [EXT_AW-1:0] exp_ad;
        bit viol;
        exp_ad = model_xlat(a);
        viol   = !rd && model_locked(a);
        tick();
        AD = a; rw = rd; DI = wdata; vma = 1'b1; ext_sel = 1'b1; cs = 1'b0; ext_dq_i = sram;
        @(negedge clk);
        check("cpu_idle_hold", hold, 0);
        if (viol) begin
            tick();
            vma = 1'b0; ext_sel = 1'b0;
            @(negedge clk);
            check("viol_cs", ext_cs, 0);
            check("viol_we_n", ext_we_n, 1);
            check("viol_hold", hold, 0);
            m_viol = 1'b1;
        end else begin
            for (int n = 0; n <= WAIT_CYC; n++) begin
                @(posedge clk);
                @(negedge clk);
                check("cpu_cs", ext_cs, 1);
                check("cpu_ad", ext_ad, exp_ad);
                check("cpu_hold", hold, (n < WAIT_CYC) ? 1 : 0);
                check("cpu_we_n", ext_we_n, (!rd && n == WAIT_CYC) ? 0 : 1);
                check("cpu_oe_n", ext_oe_n, rd ? 0 : 1);
                check("cpu_dq_oe", ext_dq_oe, rd ? 0 : 1);
                if (n == WAIT_CYC && rd) check("cpu_rdata", cpu_rdata, sram);
                if (n == WAIT_CYC && !rd) check("cpu_dq_o", ext_dq_o, wdata);
            end
            tick();
            vma = 1'b0; ext_sel = 1'b0;
            @(negedge clk);
            check("cpu_end_cs", ext_cs, 0);
        end
        $display("[%0t] cpu %s addr=%04h exp_ad=%05h viol=%0d", $time, rd ? "rd" : "wr",
                 a, exp_ad, viol);
    endtask

    task automatic vpu_fetch(input logic [15:0] va, input logic [7:0] sram);
        bit got;
        got = 0;
        tick();
        vreq = 1'b1; vaddr = va; ext_dq_i = sram;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("vid_ad", ext_ad, EXT_AW'(va));
                check("vid_oe_n", ext_oe_n, 0);
                check("vid_hold", hold, 1);
            end
            if (vack === 1'b1) begin
                got = 1;
                check("vack_latency", n, WAIT_CYC + 2);
                check("vdata", vdata, sram);
            end
        end
        if (!got) check("vack_timeout", 0, 1);
        tick();
        vreq = 1'b0;
        $display("[%0t] vpu fetch vaddr=%04h data=%02h", $time, va, vdata);
    endtask

    typedef struct {
        bit         is_wr;
        logic [2:0] off;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [5:0] e_hold, e_cs, e_vack;
        int we_low, hold_hi, vack_cnt;

        model_reset();

        // Reset state, observed while rst is still asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        ext_dq_i = 8'h3C;
        #1;
        check("rst_hold", hold, 0);
        check("rst_cs", ext_cs, 0);
        check("rst_oe_n", ext_oe_n, 1);
        check("rst_we_n", ext_we_n, 1);
        check("rst_dq_oe", ext_dq_oe, 0);
        check("rst_ad", ext_ad, 0);
        check("rst_vack", vack, 0);
        check("rst_vdata", vdata, 0);
        check("rst_DO", DO, 0);
        check("rst_cpu_rdata", cpu_rdata, 8'h3C);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) reg_read(3'(i), 8'h00, "rst_reg");

        // Single-cycle access build: one write strobe, no hold.
        tick();
        AD = 16'h1234; rw = 1'b0; DI = 8'h77; vma = 1'b1; ext_sel = 1'b1; cs = 1'b0;
        we_low = 0; hold_hi = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (w0_ext_we_n == 1'b0) we_low++;
            if (w0_hold == 1'b1) hold_hi++;
            if (n == 1) begin
                check("w0_ad", w0_ext_ad, 18'h01234);
                check("w0_dq_o", w0_ext_dq_o, 8'h77);
                check("w0_dq_oe", w0_ext_dq_oe, 1);
                tick();
                vma = 1'b0; ext_sel = 1'b0; rw = 1'b1;
            end
        end
        check("w0_we_low_cycles", we_low, 1);
        check("w0_hold_cycles", hold_hi, 0);
        $display("[%0t] wait0 write 1234<-77 we_low=%0d hold=%0d", $time, we_low, hold_hi);
        repeat (3) tick();

        // Register table.
        vecs[0]  = '{1'b1, 3'd0, 8'h85, 8'h00};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 8'h85};
        vecs[2]  = '{1'b1, 3'd1, 8'hC3, 8'h00};
        vecs[3]  = '{1'b0, 3'd1, 8'h00, 8'hC3};
        vecs[4]  = '{1'b1, 3'd2, 8'h3F, 8'h00};
        vecs[5]  = '{1'b0, 3'd2, 8'h00, 8'h1F};
        vecs[6]  = '{1'b1, 3'd5, 8'hFF, 8'h00};
        vecs[7]  = '{1'b0, 3'd5, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 3'd3, 8'hE6, 8'h00};
        vecs[9]  = '{1'b0, 3'd3, 8'h00, 8'hC6};
        vecs[10] = '{1'b0, 3'd7, 8'h00, 8'h00};
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_wr) reg_write(vecs[i].off, vecs[i].data);
            else reg_read(vecs[i].off, vecs[i].exp, "table_read");
        end

        // Translated read through window 0, then a locked write through window 1.
        cpu_ext(16'h8123, 1'b1, 8'h00, 8'h5A);
        cpu_ext(16'hA000, 1'b0, 8'h11, 8'h00);
        reg_read(3'd7, 8'h01, "status_viol");
        reg_read(3'd7, 8'h00, "status_cleared");

        // VPU and CPU arrive together: video first, CPU held straight through.
        tick();
        vreq = 1'b1; vaddr = 16'h0400; ext_dq_i = 8'hA7;
        AD = 16'h2000; rw = 1'b1; vma = 1'b1; ext_sel = 1'b1; cs = 1'b0;
        e_hold = 6'b011111;
        e_cs   = 6'b110110;
        e_vack = 6'b001000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("arb_hold", hold, e_hold[c]);
            check("arb_cs", ext_cs, e_cs[c]);
            check("arb_vack", vack, e_vack[c]);
            if (c == 1) check("arb_vid_ad", ext_ad, 18'h00400);
            if (c == 3) begin
                check("arb_vdata", vdata, 8'hA7);
                tick();
                vreq = 1'b0; ext_dq_i = 8'h5B;
            end
            if (c == 4) check("arb_cpu_ad", ext_ad, 18'h02000);
            if (c == 5) begin
                check("arb_cpu_rdata", cpu_rdata, 8'h5B);
                tick();
                vma = 1'b0; ext_sel = 1'b0;
            end
        end
        @(negedge clk);
        check("arb_end_cs", ext_cs, 0);
        $display("[%0t] arbitration vpu 0400 then cpu rd 2000", $time);

        // Reset in the first video cycle, alongside a register write that must not land.
        tick();
        vreq = 1'b1; vaddr = 16'h1111;
        tick();
        check("rstmid_pre_cs", ext_cs, 1);
        rst = 1'b1; vreq = 1'b0;
        cs = 1'b1; vma = 1'b1; rw = 1'b0; AD = 16'h0000; DI = 8'hFF;
        tick();
        rst = 1'b0; cs = 1'b0; vma = 1'b0; rw = 1'b1;
        model_reset();
        @(negedge clk);
        check("rstmid_cs", ext_cs, 0);
        check("rstmid_oe_n", ext_oe_n, 1);
        check("rstmid_hold", hold, 0);
        vack_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            if (vack === 1'b1) vack_cnt++;
            @(negedge clk);
        end
        check("rstmid_no_vack", vack_cnt, 0);
        $display("[%0t] reset during video fetch", $time);
        reg_read(3'd0, 8'h00, "rstmid_no_commit");

        // Random traffic against the model.
        for (int t = 0; t < 60; t++) begin
            int kind;
            logic [15:0] a;
            kind = $urandom_range(0, 9);
            a = 16'($urandom);
            if (kind <= 2) begin
                reg_write(3'($urandom_range(0, 7)), 8'($urandom));
            end else if (kind <= 4) begin
                logic [2:0] off;
                off = 3'($urandom_range(0, 7));
                if (off == 3'd7) reg_read(off, {7'h0, m_viol}, "rand_status");
                else reg_read(off, (int'(off) < NWIN) ? m_win[off] : 8'h00, "rand_reg");
            end else if (kind <= 7) begin
                cpu_ext(a, 1'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                vpu_fetch(a, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/extmem_ctl.md
# extmem_ctl

Parametrised external SRAM controller that replaces the fixed single-window page selector and hard-wired SRAM strobes of the 6801/68HC11 SoC. It sits between the CPU bus, the VPU video fetch port and the asynchronous external SRAM. It provides NWIN independently lockable 8 KB translation windows, a wait-state sequencer that holds the CPU clock, and arbitration of VPU fetches against CPU accesses. The top level keeps address decoding for on-chip devices and drives `ext_sel` when an access targets external memory.

## Interface
- NWIN, 4: number of translation windows; 1..7
- WIN_SLOT0, 4: 8 KB slot (AD[15:13]) mapped by window 0; window i maps slot WIN_SLOT0+i; NWIN+WIN_SLOT0 ≤ 8
- PAGE_BITS, 5: page number width; 3..6
- EXT_AW, 18: external address width; must equal max(16, 13+PAGE_BITS)
- WAIT_CYC, 1: extra wait cycles per external access; 0..7

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- AD  in  16  CPU address
- DI  in  8  CPU write data
- DO  out  8  register read data
- rw  in  1  1 = read
- vma  in  1  valid memory address
- cs  in  1  register block select; offsets AD[2:0]
- ext_sel  in  1  access targets external memory
- cpu_rdata  out  8  external read data to CPU mux
- hold  out  1  stretches the CPU clock while high
- vreq  in  1  VPU fetch request; level, held until vack
- vaddr  in  16  VPU fetch address; untranslated
- vack  out  1  one-cycle pulse; vdata valid
- vdata  out  8  captured VPU fetch byte
- ext_ad  out  EXT_AW  SRAM address
- ext_dq_i  in  8  SRAM data in
- ext_dq_o  out  8  SRAM data out
- ext_dq_oe  out  1  drive SRAM data bus
- ext_cs  out  1  SRAM chip select (active high)
- ext_oe_n  out  1  SRAM output enable
- ext_we_n  out  1  SRAM write enable

## Operation
- Window register i, offset i (i < NWIN): bit7 EN, bit6 WLOCK, bits[PAGE_BITS-1:0] PAGE; unused bits read 0. Offset 7 STATUS: bit0 VIOL (sticky), bit1 VPEND (vreq), bit2 BUSY (state≠IDLE). Reading STATUS clears VIOL. Other offsets read 0, writes ignored.
- Register writes commit on the clk edge when cs & vma & !rw.
- CPU request: ext_sel & vma & !cs. Translation applies when AD[15:13] lies in window i's slot and EN=1: ext_ad = zero-extended {PAGE, AD[12:0]}. Otherwise ext_ad = zero-extended AD. VPU addresses are never translated.
- Write to an enabled, WLOCK=1 window: no SRAM cycle, ext_we_n stays 1, hold stays 0, VIOL←1. Reads of locked windows proceed normally.
- FSM states: IDLE, CPU_ACC, VID_ACC. A counter cnt counts 0..WAIT_CYC in each access.
  - IDLE→VID_ACC on vreq (VPU has priority).
  - IDLE→CPU_ACC on a CPU request with no vreq. With WAIT_CYC=0, the access completes in IDLE-entry cycle semantics, i.e. a one-cycle CPU_ACC.
  - CPU_ACC→IDLE when cnt=WAIT_CYC.
  - VID_ACC→IDLE when cnt=WAIT_CYC. vdata←ext_dq_i on that edge; vack=1 in the following cycle.
- hold:
  - 1 while in VID_ACC.
  - 1 in IDLE when a CPU request coincides with vreq.
  - 1 in CPU_ACC while cnt<WAIT_CYC.
  - 0 in the final CPU_ACC cycle, so the CPU edge closing the access samples cpu_rdata=ext_dq_i.
- Strobes:
  - ext_cs=1 in CPU_ACC/VID_ACC.
  - ext_oe_n=0 for reads and all VID_ACC cycles.
  - ext_we_n=0 only in the final CPU_ACC cycle of a write.
  - ext_dq_oe=1 for all CPU_ACC write cycles; ext_dq_o=DI.

## Timing
- Reset values:
  - Outputs: DO=0, cpu_rdata=ext_dq_i, hold=0, vack=0, vdata=0, ext_cs=0, ext_oe_n=1, ext_we_n=1, ext_dq_oe=0, ext_ad=0.
  - Internal: all window regs 0, VIOL=0, state IDLE.
- CPU access latency: WAIT_CYC+1 cycles. VPU fetch: vreq → vack in WAIT_CYC+2 cycles.
- A vreq arriving mid-CPU_ACC waits for the CPU access to finish; it is never aborted.
- Back-to-back vreq: the new request is served from IDLE the cycle after vack.
- Write to a window register during an access: the new mapping applies from the next access only. ext_ad is latched on IDLE exit.
- Rst mid-access: IDLE next cycle, strobes released, no vack, no register commit.

## Structure
- Package `extmem_pkg`: state enum, register offsets (STATUS=7), field bit positions (EN=7, WLOCK=6, VIOL/VPEND/BUSY).
- Sub-module `extmem_winreg`: window register file, lock check, and combinational address translation. The FSM, counter and strobes live in `extmem_ctl`.

## Test plan
- Reset, then read offsets 0..7 → all 0; ext_we_n=1, ext_oe_n=1, hold=0.
- Write $85 to reg 0; CPU reads $8123 (ext_sel) → ext_ad=$0A123, hold high 1 cycle (WAIT_CYC=1), cpu_rdata=$5A when SRAM drives $5A.
- Write $C3 to reg 1; CPU writes $A000 → no SRAM write, hold=0. STATUS reads $01, then $00 on the next read.
- vreq with vaddr=$0400 and a simultaneous CPU read of $2000 → VID_ACC first, vack after 3 cycles with vdata=SRAM byte. CPU access follows, hold continuous until its final cycle.
- WAIT_CYC=0 build: CPU write $1234←$77 → ext_we_n low exactly one cycle, hold never asserted.
- Assert rst during VID_ACC cycle 1 → IDLE next cycle, no vack, ext_cs=0.
